nano_ctrl_seq: RTL and testbench

Multi-cycle, parametrised successor to the nanoRisc combinational control unit.
- Sequences each instruction through fetch, optional immediate fetch, execute and memory-wait phases, instead of decoding in a single cycle.
- Holds the mode flags (unsigned, aluIn, stackRepo) in real flops and resolves halt properly.
- Sits between the instruction ROM, PC, register bank, ALU/accumulator, stack and RAM.

---
 rtl/nano_ctrl_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_nano_ctrl_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nano_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : nano_ctrl_seq
// Brief    : Multi-cycle nanoRisc control sequencer (fetch/imm/exec/memwait).
// Revision : 1.0 - initial release
// ============================================================================

module nano_ctrl_seq #(
    parameter int INSTR_W     = 8,
    parameter int SEL_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [1:0]         cmp_flags,
    input  logic               mem_ack,
    input  logic               resume,
    output logic [INSTR_W-1:0] imm,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [1:0]         pc_src,
    output logic               ram_rd,
    output logic               ram_wr,
    output logic               rb_rd,
    output logic               rb_wr,
    output logic [SEL_W-1:0]   rb_rsel,
    output logic [SEL_W-1:0]   rb_wsel,
    output logic [3:0]         alu_op,
    output logic               acc_wr,
    output logic               acc_clr,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_clr,
    output logic               mode_unsigned,
    output logic               mode_alu_in,
    output logic               mode_stack_repo,
    output logic               halted,
    output logic               illegal,
    output logic               mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] c_OP_LWM = 4'b0000;
    localparam logic [3:0] c_OP_LWI = 4'b0001;
    localparam logic [3:0] c_OP_SWM = 4'b0010;
    localparam logic [3:0] c_OP_SWI = 4'b0011;
    localparam logic [3:0] c_OP_ATR = 4'b0100;
    localparam logic [3:0] c_OP_RTA = 4'b0101;
    localparam logic [3:0] c_OP_SHR = 4'b0110;
    localparam logic [3:0] c_OP_SHL = 4'b0111;
    localparam logic [3:0] c_OP_ALU = 4'b1000;
    localparam logic [3:0] c_OP_PSR = 4'b1001;
    localparam logic [3:0] c_OP_STK = 4'b1010;
    localparam logic [3:0] c_OP_BRA = 4'b1011;
    localparam logic [3:0] c_OP_BR  = 4'b1100;
    localparam logic [3:0] c_OP_LWR = 4'b1101;
    localparam logic [3:0] c_OP_SWR = 4'b1110;

    localparam logic [SEL_W-1:0] c_SEL_LINK = SEL_W'(10);
    localparam logic [SEL_W-1:0] c_SEL_ADDR = SEL_W'(12);
    localparam logic [SEL_W-1:0] c_SEL_SWR  = SEL_W'(14);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IMM   = 3'd1,
        S_EXEC  = 3'd2,
        S_MEMW  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_imm;
    logic               r_mode_uns;
    logic               r_mode_alu;
    logic               r_mode_repo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_err;

    function automatic logic f_alu_imm(input logic [3:0] fn);
        case (fn)
            4'b0001, 4'b0011, 4'b1011, 4'b1101: f_alu_imm = 1'b1;
            default:                            f_alu_imm = 1'b0;
        endcase
    endfunction

    function automatic logic f_needs_imm(input logic [INSTR_W-1:0] b);
        logic [3:0] op;
        logic [3:0] fn;
        op = b[INSTR_W-1 -: 4];
        fn = b[3:0];
        case (op)
            c_OP_LWM, c_OP_LWI, c_OP_SWM,
            c_OP_SWI, c_OP_LWR, c_OP_SWR: f_needs_imm = 1'b1;
            c_OP_STK: f_needs_imm = (fn == 4'b0000);
            c_OP_BRA: f_needs_imm = (fn <= 4'b0100);
            c_OP_ALU: f_needs_imm = f_alu_imm(fn);
            default:  f_needs_imm = 1'b0;
        endcase
    endfunction

    logic [3:0]       w_op;
    logic [3:0]       w_fn;
    logic [SEL_W-1:0] w_sel;

    assign w_op  = r_ir[INSTR_W-1 -: 4];
    assign w_fn  = r_ir[3:0];
    assign w_sel = r_ir[SEL_W-1:0];

    logic             w_ram_rd, w_ram_wr, w_rb_rd, w_rb_wr;
    logic [SEL_W-1:0] w_rsel, w_wsel;
    logic [3:0]       w_alu_op;
    logic             w_acc_wr, w_acc_clr, w_push, w_pop, w_sclr;
    logic             w_pc_load, w_take;
    logic [1:0]       w_pc_src;
    logic             w_illegal, w_mem, w_load, w_halt;
    logic             w_set_uns, w_clr_uns, w_tog_repo, w_tog_alu;

    // Decode of the latched instruction; only applied while in EXEC/MEMW.
    always_comb begin
        w_ram_rd   = 1'b0;
        w_ram_wr   = 1'b0;
        w_rb_rd    = 1'b0;
        w_rb_wr    = 1'b0;
        w_rsel     = '0;
        w_wsel     = '0;
        w_alu_op   = 4'b0000;
        w_acc_wr   = 1'b0;
        w_acc_clr  = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_sclr     = 1'b0;
        w_pc_load  = 1'b0;
        w_pc_src   = 2'b00;
        w_take     = 1'b0;
        w_illegal  = 1'b0;
        w_mem      = 1'b0;
        w_load     = 1'b0;
        w_halt     = 1'b0;
        w_set_uns  = 1'b0;
        w_clr_uns  = 1'b0;
        w_tog_repo = 1'b0;
        w_tog_alu  = 1'b0;
        case (w_op)
            c_OP_LWM: begin
                w_ram_rd = 1'b1; w_wsel = w_sel; w_mem = 1'b1; w_load = 1'b1;
            end
            c_OP_LWI: begin
                w_rb_wr = 1'b1; w_wsel = w_sel;
            end
            c_OP_SWM, c_OP_SWI: begin
                w_ram_wr = 1'b1; w_rb_rd = 1'b1; w_rsel = w_sel; w_mem = 1'b1;
            end
            c_OP_ATR: begin
                w_rb_wr = 1'b1; w_wsel = w_sel;
            end
            c_OP_RTA: begin
                w_rb_rd = 1'b1; w_rsel = w_sel; w_acc_wr = 1'b1;
            end
            c_OP_SHR, c_OP_SHL: begin
                w_alu_op = w_op;
                if (w_fn[3]) begin
                    w_acc_wr = 1'b1;
                end else begin
                    w_rb_rd = 1'b1; w_rb_wr = 1'b1;
                    w_rsel  = w_sel; w_wsel = w_sel;
                end
            end
            c_OP_ALU: begin
                w_alu_op = w_fn;
                // comp only updates the flags, so it never writes a result
                if (w_fn != 4'b1111) begin
                    if (r_mode_alu) w_push   = 1'b1;
                    else            w_acc_wr = 1'b1;
                end
                if (!f_alu_imm(w_fn) && r_mode_repo) w_pop = 1'b1;
            end
            c_OP_PSR: begin
                w_push = 1'b1; w_rb_rd = 1'b1; w_rsel = w_sel;
            end
            c_OP_STK: begin
                case (w_fn)
                    4'b0000: w_push     = 1'b1;
                    4'b0001: w_set_uns  = 1'b1;
                    4'b0010: w_pop      = 1'b1;
                    4'b0011: w_sclr     = 1'b1;
                    4'b0100: w_acc_clr  = 1'b1;
                    4'b0101: w_tog_repo = 1'b1;
                    4'b0110: w_tog_alu  = 1'b1;
                    4'b0111: w_clr_uns  = 1'b1;
                    default: w_illegal  = 1'b1;
                endcase
            end
            c_OP_BRA: begin
                // bne has no immediate byte of its own and targets the last latched one
                case (w_fn)
                    4'b0000: w_take = 1'b1;
                    4'b0001: w_take = (cmp_flags == 2'b00);
                    4'b0010: w_take = (cmp_flags == 2'b01);
                    4'b0011: w_take = (cmp_flags == 2'b10);
                    4'b0100: begin
                        w_take = 1'b1; w_rb_wr = 1'b1; w_wsel = c_SEL_LINK;
                    end
                    4'b0101: w_take = (cmp_flags != 2'b01);
                    4'b0110: w_halt = 1'b1;
                    default: w_illegal = 1'b1;
                endcase
                if (w_take) begin
                    w_pc_load = 1'b1; w_pc_src = 2'b10;
                end
            end
            c_OP_BR: begin
                w_rb_rd = 1'b1; w_rsel = w_sel; w_pc_load = 1'b1; w_pc_src = 2'b01;
            end
            c_OP_LWR: begin
                w_ram_rd = 1'b1; w_rsel = c_SEL_ADDR; w_wsel = w_sel;
                w_mem    = 1'b1; w_load = 1'b1;
            end
            c_OP_SWR: begin
                w_ram_wr = 1'b1; w_rsel = w_sel; w_rb_wr = 1'b1; w_wsel = c_SEL_SWR;
                w_mem    = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Output gating by phase: strobes only in EXEC/MEMW, fetch handshake otherwise.
    always_comb begin
        instr_ready = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_src      = 2'b00;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        rb_rd       = 1'b0;
        rb_wr       = 1'b0;
        rb_rsel     = '0;
        rb_wsel     = '0;
        alu_op      = 4'b0000;
        acc_wr      = 1'b0;
        acc_clr     = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_clr     = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH, S_IMM: begin
                instr_ready = 1'b1;
                pc_inc      = instr_valid;
            end
            S_EXEC: begin
                pc_load  = w_pc_load;
                pc_src   = w_pc_src;
                ram_rd   = w_ram_rd;
                ram_wr   = w_ram_wr;
                rb_rd    = w_rb_rd;
                rb_wr    = w_rb_wr;
                rb_rsel  = w_rsel;
                rb_wsel  = w_wsel;
                alu_op   = w_alu_op;
                acc_wr   = w_acc_wr;
                acc_clr  = w_acc_clr;
                stk_push = w_push;
                stk_pop  = w_pop;
                stk_clr  = w_sclr;
                illegal  = w_illegal;
            end
            S_MEMW: begin
                ram_rd  = w_ram_rd;
                ram_wr  = w_ram_wr;
                rb_rd   = w_rb_rd;
                rb_rsel = w_rsel;
                rb_wsel = w_wsel;
                rb_wr   = w_load & mem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_ir        <= '0;
            r_imm       <= '0;
            r_mode_uns  <= 1'b0;
            r_mode_alu  <= 1'b0;
            r_mode_repo <= 1'b0;
            r_cnt       <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= f_needs_imm(instr) ? S_IMM : S_EXEC;
                    end
                end
                S_IMM: begin
                    if (instr_valid) begin
                        r_imm   <= instr;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_set_uns)  r_mode_uns  <= 1'b1;
                    if (w_clr_uns)  r_mode_uns  <= 1'b0;
                    if (w_tog_repo) r_mode_repo <= ~r_mode_repo;
                    if (w_tog_alu)  r_mode_alu  <= ~r_mode_alu;
                    r_cnt <= '0;
                    if (w_halt)     r_state <= S_HALT;
                    else if (w_mem) r_state <= S_MEMW;
                    else            r_state <= S_FETCH;
                end
                S_MEMW: begin
                    // Strobes stay up for MEM_TIMEOUT wait cycles; the error pulse follows the last one.
                    if (mem_ack) begin
                        r_state <= S_FETCH;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= S_FETCH;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HALT: begin
                    if (resume) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imm             = r_imm;
    assign mode_unsigned   = r_mode_uns;
    assign mode_alu_in     = r_mode_alu;
    assign mode_stack_repo = r_mode_repo;
    assign halted          = (r_state == S_HALT);
    assign mem_err         = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_nano_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nano_ctrl_seq
// Brief    : Directed self-checking bench for nano_ctrl_seq.
// Revision : 1.0 - initial release
// ============================================================================

module tb_nano_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] cmp_flags;
    logic       mem_ack;
    logic       resume;
    logic [7:0] imm;
    logic       pc_inc, pc_load;
    logic [1:0] pc_src;
    logic       ram_rd, ram_wr, rb_rd, rb_wr;
    logic [3:0] rb_rsel, rb_wsel, alu_op;
    logic       acc_wr, acc_clr, stk_push, stk_pop, stk_clr;
    logic       mode_unsigned, mode_alu_in, mode_stack_repo;
    logic       halted, illegal, mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    nano_ctrl_seq #(.INSTR_W(8), .SEL_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .cmp_flags(cmp_flags), .mem_ack(mem_ack),
        .resume(resume), .imm(imm), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_src(pc_src), .ram_rd(ram_rd), .ram_wr(ram_wr), .rb_rd(rb_rd),
        .rb_wr(rb_wr), .rb_rsel(rb_rsel), .rb_wsel(rb_wsel), .alu_op(alu_op),
        .acc_wr(acc_wr), .acc_clr(acc_clr), .stk_push(stk_push),
        .stk_pop(stk_pop), .stk_clr(stk_clr), .mode_unsigned(mode_unsigned),
        .mode_alu_in(mode_alu_in), .mode_stack_repo(mode_stack_repo),
        .halted(halted), .illegal(illegal), .mem_err(mem_err)
    );

    // Everything except illegal, for the "no other strobe" checks.
    logic [25:0] strobes;
    assign strobes = {ram_rd, ram_wr, rb_rd, rb_wr, acc_wr, acc_clr, stk_push,
                      stk_pop, stk_clr, pc_load, pc_inc, pc_src, alu_op,
                      rb_rsel, rb_wsel, mem_err};
    logic [2:0] modes;
    assign modes = {mode_unsigned, mode_alu_in, mode_stack_repo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic clk_step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        instr       = b;
        instr_valid = 1'b1;
        clk_step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) clk_step();
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b expected 0", halted); end
        n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", instr_ready); end
        n_cmp++; if (imm !== 8'h00) begin n_bad++; $display("FAIL rst_imm: got %h expected 00", imm); end
        n_cmp++; if (modes !== 3'b000) begin n_bad++; $display("FAIL rst_modes: got %b expected 000", modes); end
        n_cmp++; if (strobes !== 26'd0 || illegal !== 1'b0) begin n_bad++; $display("FAIL rst_strobes: got %h expected 0", strobes); end
        rst_n = 1'b1;
    endtask

    task automatic test_lwi();
        instr = 8'h13; instr_valid = 1'b1; #1;
        n_cmp++; if (pc_inc !== 1'b1 || instr_ready !== 1'b1) begin n_bad++; $display("FAIL lwi_fetch: got inc=%b rdy=%b expected 1 1", pc_inc, instr_ready); end
        clk_step();
        instr = 8'h5A; #1;
        n_cmp++; if (pc_inc !== 1'b1 || rb_wr !== 1'b0) begin n_bad++; $display("FAIL lwi_imm: got inc=%b wr=%b expected 1 0", pc_inc, rb_wr); end
        clk_step();
        instr_valid = 1'b0; #1;
        n_cmp++; if (imm !== 8'h5A) begin n_bad++; $display("FAIL lwi_immval: got %h expected 5a", imm); end
        n_cmp++; if (rb_wr !== 1'b1 || rb_wsel !== 4'd3 || pc_inc !== 1'b0) begin n_bad++; $display("FAIL lwi_exec: got wr=%b wsel=%0d inc=%b expected 1 3 0", rb_wr, rb_wsel, pc_inc); end
        clk_step(); #1;
        n_cmp++; if (rb_wr !== 1'b0 || instr_ready !== 1'b1) begin n_bad++; $display("FAIL lwi_after: got wr=%b rdy=%b expected 0 1", rb_wr, instr_ready); end
    endtask

    task automatic test_lwm();
        int rd_cnt, wr_cnt, wr_at, err_cnt, err_at;
        send_byte(8'h02);
        send_byte(8'h10);
        rd_cnt = 0; wr_cnt = 0; wr_at = -1;
        for (int k = 0; k < 6; k++) begin
            mem_ack = (k == 3);
            #1;
            if (ram_rd) rd_cnt++;
            if (rb_wr) begin wr_cnt++; wr_at = k; end
            if (k == 0) begin
                n_cmp++; if (rb_wsel !== 4'd2) begin n_bad++; $display("FAIL lwm_wsel: got %0d expected 2", rb_wsel); end
            end
            clk_step();
        end
        mem_ack = 1'b0;
        n_cmp++; if (rd_cnt != 4) begin n_bad++; $display("FAIL lwm_rd_cycles: got %0d expected 4", rd_cnt); end
        n_cmp++; if (wr_cnt != 1 || wr_at != 3) begin n_bad++; $display("FAIL lwm_wr_ack: got cnt=%0d at=%0d expected 1 3", wr_cnt, wr_at); end

        send_byte(8'h02);
        send_byte(8'h10);
        rd_cnt = 0; wr_cnt = 0; err_cnt = 0; err_at = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (ram_rd) rd_cnt++;
            if (rb_wr) wr_cnt++;
            if (mem_err) begin err_cnt++; err_at = k; end
            clk_step();
        end
        n_cmp++; if (rd_cnt != 16) begin n_bad++; $display("FAIL lwm_to_rd: got %0d expected 16", rd_cnt); end
        n_cmp++; if (err_cnt != 1 || err_at != 16) begin n_bad++; $display("FAIL lwm_to_err: got cnt=%0d at=%0d expected 1 16", err_cnt, err_at); end
        n_cmp++; if (wr_cnt != 0) begin n_bad++; $display("FAIL lwm_to_nowr: got %0d expected 0", wr_cnt); end
    endtask

    task automatic test_alu_mode();
        send_byte(8'hA6); #1;
        n_cmp++; if (mode_alu_in !== 1'b0 || stk_push !== 1'b0) begin n_bad++; $display("FAIL aaim_exec: got mode=%b push=%b expected 0 0", mode_alu_in, stk_push); end
        clk_step(); #1;
        n_cmp++; if (mode_alu_in !== 1'b1) begin n_bad++; $display("FAIL aaim_set: got %b expected 1", mode_alu_in); end
        send_byte(8'h80); #1;
        n_cmp++; if (stk_push !== 1'b1 || acc_wr !== 1'b0) begin n_bad++; $display("FAIL add_stack: got push=%b acc=%b expected 1 0", stk_push, acc_wr); end
        clk_step();
        send_byte(8'hA6);
        clk_step();
        send_byte(8'h80); #1;
        n_cmp++; if (stk_push !== 1'b0 || acc_wr !== 1'b1 || mode_alu_in !== 1'b0) begin n_bad++; $display("FAIL add_acc: got push=%b acc=%b mode=%b expected 0 1 0", stk_push, acc_wr, mode_alu_in); end
        clk_step();
        send_byte(8'hA5);
        clk_step();
        send_byte(8'h80); #1;
        n_cmp++; if (stk_pop !== 1'b1 || acc_wr !== 1'b1) begin n_bad++; $display("FAIL add_repo: got pop=%b acc=%b expected 1 1", stk_pop, acc_wr); end
        clk_step();
        send_byte(8'hA5);
        clk_step(); #1;
        n_cmp++; if (mode_stack_repo !== 1'b0) begin n_bad++; $display("FAIL srep_toggle: got %b expected 0", mode_stack_repo); end
    endtask

    task automatic test_branch();
        send_byte(8'hB5);
        cmp_flags = 2'b01; #1;
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL bne_eq: got %b expected 0", pc_load); end
        clk_step();
        send_byte(8'hB5);
        cmp_flags = 2'b10; #1;
        n_cmp++; if (pc_load !== 1'b1 || pc_src !== 2'b10) begin n_bad++; $display("FAIL bne_gt: got ld=%b src=%b expected 1 10", pc_load, pc_src); end
        clk_step();
        send_byte(8'hB1);
        send_byte(8'h40);
        cmp_flags = 2'b00; #1;
        n_cmp++; if (pc_load !== 1'b1 || imm !== 8'h40) begin n_bad++; $display("FAIL bil_lt: got ld=%b imm=%h expected 1 40", pc_load, imm); end
        clk_step();
        send_byte(8'hB1);
        send_byte(8'h41);
        cmp_flags = 2'b10; #1;
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL bil_gt: got %b expected 0", pc_load); end
        clk_step();
        cmp_flags = 2'b00;
    endtask

    task automatic test_halt();
        send_byte(8'hB6);
        clk_step();
        for (int k = 0; k < 5; k++) begin
            instr = 8'h13; instr_valid = 1'b1; #1;
            n_cmp++; if (halted !== 1'b1 || instr_ready !== 1'b0 || pc_inc !== 1'b0) begin n_bad++; $display("FAIL halt_hold%0d: got h=%b rdy=%b inc=%b expected 1 0 0", k, halted, instr_ready, pc_inc); end
            clk_step();
        end
        resume = 1'b1;
        clk_step();
        resume = 1'b0; instr_valid = 1'b0; #1;
        n_cmp++; if (halted !== 1'b0 || instr_ready !== 1'b1) begin n_bad++; $display("FAIL halt_resume: got h=%b rdy=%b expected 0 1", halted, instr_ready); end
    endtask

    task automatic test_illegal();
        send_byte(8'hF3); #1;
        n_cmp++; if (illegal !== 1'b1 || strobes !== 26'd0) begin n_bad++; $display("FAIL ill_op: got ill=%b str=%h expected 1 0", illegal, strobes); end
        clk_step(); #1;
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL ill_once: got %b expected 0", illegal); end
        send_byte(8'hA9); #1;
        n_cmp++; if (illegal !== 1'b1 || strobes !== 26'd0) begin n_bad++; $display("FAIL ill_a9: got ill=%b str=%h expected 1 0", illegal, strobes); end
        clk_step();
    endtask

    task automatic test_reset_memw();
        send_byte(8'hA1);
        clk_step();
        send_byte(8'hA6);
        clk_step(); #1;
        n_cmp++; if (modes !== 3'b110) begin n_bad++; $display("FAIL modes_set: got %b expected 110", modes); end
        send_byte(8'h02);
        send_byte(8'h10);
        clk_step(); #1;
        n_cmp++; if (ram_rd !== 1'b1) begin n_bad++; $display("FAIL memw_rd: got %b expected 1", ram_rd); end
        rst_n = 1'b0; #1;
        n_cmp++; if (ram_rd !== 1'b0 || modes !== 3'b000) begin n_bad++; $display("FAIL async_rst: got rd=%b modes=%b expected 0 000", ram_rd, modes); end
        n_cmp++; if (imm !== 8'h00 || instr_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_state: got imm=%h rdy=%b expected 00 1", imm, instr_ready); end
        clk_step();
        rst_n = 1'b1;
        clk_step();
    endtask

    initial begin
        rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0;
        cmp_flags = 2'b00; mem_ack = 1'b0; resume = 1'b0;
        test_reset();
        test_lwi();
        test_lwm();
        test_alu_mode();
        test_branch();
        test_halt();
        test_illegal();
        test_reset_memw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
